// File: rtl/imm_enc_pkg.sv
// imm_enc_pkg
// Shared definitions for the immediate encoder: the RV32I immediate format
// codes and, per format, the 32-bit mask of instruction bit positions that
// carry immediate bits.
// Ports: none (package).
package imm_enc_pkg;

    typedef enum logic [2:0] {
        FMT_I = 3'b000,
        FMT_S = 3'b001,
        FMT_B = 3'b011,
        FMT_U = 3'b100,
        FMT_J = 3'b101
    } imm_fmt_t;

    // S and B use the same instruction bit positions, as do U and J.
    localparam logic [31:0] MASK_I = 32'hFFF0_0000;
    localparam logic [31:0] MASK_S = 32'hFE00_0F80;
    localparam logic [31:0] MASK_B = 32'hFE00_0F80;
    localparam logic [31:0] MASK_U = 32'hFFFF_F000;
    localparam logic [31:0] MASK_J = 32'hFFFF_F000;

    // Illegal codes map to an empty mask so base_inst passes through untouched.
    function automatic logic [31:0] fmt_mask(input logic [2:0] fmt);
        case (fmt)
            FMT_I:   fmt_mask = MASK_I;
            FMT_S:   fmt_mask = MASK_S;
            FMT_B:   fmt_mask = MASK_B;
            FMT_U:   fmt_mask = MASK_U;
            FMT_J:   fmt_mask = MASK_J;
            default: fmt_mask = 32'h0000_0000;
        endcase
    endfunction

endpackage

// File: rtl/imm_scatter.sv
// imm_scatter
// Purely combinational core of the encoder: range-checks a signed immediate
// against the selected RV32I format and scatters it into the immediate bit
// positions of base_inst.
// Ports:
//   fmt       in   3   format code (imm_fmt_t encoding, other codes illegal)
//   imm       in   32  signed immediate (byte offset for B/J)
//   base_inst in   32  instruction supplying all non-immediate bits
//   inst      out  32  encoded instruction
//   err       out  1   range or format error
module imm_scatter
    import imm_enc_pkg::*;
(
    input  logic [2:0]  fmt,
    input  logic [31:0] imm,
    input  logic [31:0] base_inst,
    output logic [31:0] inst,
    output logic        err
);

    logic [31:0] placed;
    logic [31:0] mask;
    logic        range_ok;
    logic        fmt_ok;

    always_comb begin
        placed   = 32'h0000_0000;
        range_ok = 1'b0;
        fmt_ok   = 1'b1;
        mask     = fmt_mask(fmt);

        // Range checks test that the discarded high bits are pure sign extension.
        case (fmt)
            FMT_I: begin
                placed[31:20] = imm[11:0];
                range_ok      = (&imm[31:11]) | ~(|imm[31:11]);
            end
            FMT_S: begin
                placed[31:25] = imm[11:5];
                placed[11:7]  = imm[4:0];
                range_ok      = (&imm[31:11]) | ~(|imm[31:11]);
            end
            FMT_B: begin
                placed[31]    = imm[12];
                placed[30:25] = imm[10:5];
                placed[11:8]  = imm[4:1];
                placed[7]     = imm[11];
                range_ok      = ~imm[0] & ((&imm[31:12]) | ~(|imm[31:12]));
            end
            FMT_U: begin
                placed[31:12] = imm[31:12];
                range_ok      = ~(|imm[11:0]);
            end
            FMT_J: begin
                placed[31]    = imm[20];
                placed[30:21] = imm[10:1];
                placed[20]    = imm[11];
                placed[19:12] = imm[19:12];
                range_ok      = ~imm[0] & ((&imm[31:20]) | ~(|imm[31:20]));
            end
            default: begin
                fmt_ok = 1'b0;
            end
        endcase

        err = ~fmt_ok | ~range_ok;

        // An errored result still clears the immediate field so a bad value
        // never leaks partially into the injected instruction.
        if (!fmt_ok) begin
            inst = base_inst;
        end else if (err) begin
            inst = base_inst & ~mask;
        end else begin
            inst = (base_inst & ~mask) | placed;
        end
    end

endmodule

// File: rtl/imm_encoder_unit.sv
// imm_encoder_unit
// Two-stage valid/ready pipeline that encodes a signed immediate into an
// RV32I instruction word. Stage 1 registers the request, stage 2 registers
// the output of imm_scatter.
// Optional feature: define IMM_ENC_ERR_CNT_EN to build a saturating counter
// of errored results on err_cnt; otherwise err_cnt is tied to zero.
// Ports:
//   clk        in   1           system clock, rising edge
//   rst_n      in   1           asynchronous active-low reset
//   in_valid   in   1           request valid
//   in_ready   out  1           request accepted when in_valid && in_ready
//   fmt        in   3           format code
//   imm        in   DATA_WIDTH  signed immediate
//   base_inst  in   DATA_WIDTH  instruction providing non-immediate bits
//   out_valid  out  1           result valid
//   out_ready  in   1           consumer ready
//   out_inst   out  DATA_WIDTH  encoded instruction
//   out_err    out  1           range or format error for this result
//   err_cnt    out  CNT_WIDTH   saturating count of errored results
module imm_encoder_unit
    import imm_enc_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            fmt,
    input  logic [DATA_WIDTH-1:0] imm,
    input  logic [DATA_WIDTH-1:0] base_inst,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_inst,
    output logic                  out_err,
    output logic [CNT_WIDTH-1:0]  err_cnt
);

    logic                  s1_valid;
    logic [2:0]            s1_fmt;
    logic [DATA_WIDTH-1:0] s1_imm;
    logic [DATA_WIDTH-1:0] s1_base;

    logic [DATA_WIDTH-1:0] enc_inst;
    logic                  enc_err;

    logic accept;
    logic advance;

    // Stage 1 may refill in the same cycle it hands off, so a full stage 1
    // only blocks when the output register is also stuck.
    assign in_ready = ~s1_valid | ~out_valid | out_ready;
    assign accept   = in_valid & in_ready;
    assign advance  = s1_valid & (~out_valid | out_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_fmt   <= 3'b000;
            s1_imm   <= '0;
            s1_base  <= '0;
        end else begin
            if (accept) begin
                s1_valid <= 1'b1;
                s1_fmt   <= fmt;
                s1_imm   <= imm;
                s1_base  <= base_inst;
            end else if (advance) begin
                s1_valid <= 1'b0;
            end
        end
    end

    imm_scatter u_scatter (
        .fmt       (s1_fmt),
        .imm       (s1_imm),
        .base_inst (s1_base),
        .inst      (enc_inst),
        .err       (enc_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_inst  <= '0;
            out_err   <= 1'b0;
        end else begin
            if (advance) begin
                out_valid <= 1'b1;
                out_inst  <= enc_inst;
                out_err   <= enc_err;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef IMM_ENC_ERR_CNT_EN
    logic [CNT_WIDTH-1:0] err_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else if (advance && enc_err && (err_cnt_q != {CNT_WIDTH{1'b1}})) begin
            err_cnt_q <= err_cnt_q + 1'b1;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_imm_encoder_unit.sv
// tb_imm_encoder_unit
// Directed testbench for imm_encoder_unit. Stimulus pushes hand-computed
// expected results into a scoreboard queue on accept; a monitor pops and
// compares on every output transfer and checks that held outputs stay stable.
module tb_imm_encoder_unit;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  fmt;
    logic [31:0] imm;
    logic [31:0] base_inst;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic        out_err;
    logic [7:0]  err_cnt;

    typedef struct {
        logic [31:0] inst;
        logic        err;
    } exp_t;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] imm;
        logic [31:0] base;
        logic [31:0] inst;
        logic        err;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[13];
    vec_t bp_vecs[5];

    int checks;
    int errors;
    int exp_err_cnt;

    logic        hold_pending;
    logic [31:0] held_inst;
    logic        held_err;

    imm_encoder_unit #(
        .DATA_WIDTH (32),
        .CNT_WIDTH  (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .fmt       (fmt),
        .imm       (imm),
        .base_inst (base_inst),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_inst  (out_inst),
        .out_err   (out_err),
        .err_cnt   (err_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge with
    // in_valid still high so calls can be chained back to back.
    task automatic applyStimulus(input vec_t v);
        int waited;
        exp_t e;
        fmt       = v.f;
        imm       = v.imm;
        base_inst = v.base;
        in_valid  = 1'b1;
        waited    = 0;
        @(negedge clk);
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout actual=in_ready_low required=accept");
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            e.inst = v.inst;
            e.err  = v.err;
            sb_q.push_back(e);
            #1;
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        checkOutput("drain_left", sb_q.size(), 0);
    endtask

    // Monitor: compare every transfer against the scoreboard, and require
    // stalled outputs to hold their value.
    initial begin
        exp_t e;
        hold_pending = 1'b0;
        held_inst    = '0;
        held_err     = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold_pending = 1'b0;
            end else begin
                if (hold_pending) begin
                    checkOutput("hold_valid", {31'b0, out_valid}, 32'd1);
                    checkOutput("hold_inst", out_inst, held_inst);
                    checkOutput("hold_err", {31'b0, out_err}, {31'b0, held_err});
                end
                if (out_valid && out_ready) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_output actual=%h required=none", out_inst);
                    end else begin
                        e = sb_q.pop_front();
                        checkOutput("out_inst", out_inst, e.inst);
                        checkOutput("out_err", {31'b0, out_err}, {31'b0, e.err});
                        if (e.err) exp_err_cnt++;
                    end
                end
                hold_pending = out_valid & ~out_ready;
                held_inst    = out_inst;
                held_err     = out_err;
            end
        end
    end

    initial begin
        vec_t v;
        checks      = 0;
        errors      = 0;
        exp_err_cnt = 0;

        //          fmt     imm           base          expected inst err
        vecs[0]  = '{3'b000, 32'hFFFFFFFF, 32'h00000013, 32'hFFF00013, 1'b0};
        vecs[1]  = '{3'b001, 32'h00000800, 32'hFFFFFFFF, 32'h01FFF07F, 1'b1};
        vecs[2]  = '{3'b011, 32'hFFFFF000, 32'h00000063, 32'h80000063, 1'b0};
        vecs[3]  = '{3'b011, 32'h00000003, 32'hFFFFFFE3, 32'h01FFF063, 1'b1};
        vecs[4]  = '{3'b101, 32'h000FFFFE, 32'h0000006F, 32'h7FFFF06F, 1'b0};
        vecs[5]  = '{3'b100, 32'h12345000, 32'h00000537, 32'h12345537, 1'b0};
        vecs[6]  = '{3'b100, 32'h12345001, 32'hFFFFFFFF, 32'h00000FFF, 1'b1};
        vecs[7]  = '{3'b001, 32'hFFFFF800, 32'h00000023, 32'h80000023, 1'b0};
        vecs[8]  = '{3'b000, 32'h000007FF, 32'h00000013, 32'h7FF00013, 1'b0};
        vecs[9]  = '{3'b000, 32'hFFFFF7FF, 32'hFFFFFFFF, 32'h000FFFFF, 1'b1};
        vecs[10] = '{3'b101, 32'h00100000, 32'h0000006F, 32'h0000006F, 1'b1};
        vecs[11] = '{3'b001, 32'hFFFFFFFF, 32'h00002023, 32'hFE002FA3, 1'b0};
        vecs[12] = '{3'b101, 32'hFFFFFFFE, 32'h0000006F, 32'hFFFFF06F, 1'b0};

        bp_vecs[0] = '{3'b001, 32'h00000800, 32'hABCDEF23, 32'h01CDE023, 1'b1};
        bp_vecs[1] = '{3'b000, 32'h00000123, 32'h00000513, 32'h12300513, 1'b0};
        bp_vecs[2] = '{3'b011, 32'h00000003, 32'h00000063, 32'h00000063, 1'b1};
        bp_vecs[3] = '{3'b010, 32'h00000005, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1};
        bp_vecs[4] = '{3'b111, 32'h00000000, 32'h12345678, 32'h12345678, 1'b1};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        fmt       = 3'b000;
        imm       = '0;
        base_inst = '0;
        out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("rst_in_ready", {31'b0, in_ready}, 32'd1);
        checkOutput("rst_out_inst", out_inst, 32'd0);
        checkOutput("rst_out_err", {31'b0, out_err}, 32'd0);
        checkOutput("rst_err_cnt", {24'b0, err_cnt}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // First transfer alone to pin down the two-cycle latency.
        applyStimulus(vecs[0]);
        idle();
        checkOutput("latency_c1", {31'b0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("latency_c2", {31'b0, out_valid}, 32'd1);
        waitDrain();

        for (int i = 1; i < 13; i++) begin
            applyStimulus(vecs[i]);
        end
        idle();
        waitDrain();

        // Backpressure: two accepts fill both stages, then in_ready must drop.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        applyStimulus(bp_vecs[0]);
        applyStimulus(bp_vecs[1]);
        v = bp_vecs[2];
        fmt       = v.f;
        imm       = v.imm;
        base_inst = v.base;
        in_valid  = 1'b1;
        #1;
        checkOutput("bp_in_ready", {31'b0, in_ready}, 32'd0);
        checkOutput("bp_out_valid", {31'b0, out_valid}, 32'd1);
        idle();
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int i = 2; i < 5; i++) begin
            applyStimulus(bp_vecs[i]);
        end
        idle();
        waitDrain();

`ifdef IMM_ENC_ERR_CNT_EN
        checkOutput("err_cnt", {24'b0, err_cnt}, exp_err_cnt);
`else
        checkOutput("err_cnt_tied", {24'b0, err_cnt}, 32'd0);
`endif

        // Reset with a request in stage 1: it must vanish without output.
        applyStimulus('{3'b000, 32'h00000001, 32'h00000013, 32'h00100013, 1'b0});
        idle();
        rst_n = 1'b0;
        sb_q.delete();
        exp_err_cnt = 0;
        #1;
        checkOutput("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        checkOutput("midrst_err_cnt", {24'b0, err_cnt}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        applyStimulus(vecs[4]);
        idle();
        waitDrain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imm_encoder_unit.md
Name: imm_encoder_unit

Overview:
- Inverse of the immediate sign-extension path: takes a 32-bit signed immediate value plus a format code and scatters it into the RV32I immediate bit positions of an instruction word.
- Range-checks the immediate against the selected format; non-immediate bits come from a base instruction word.
- Two-stage valid/ready pipeline feeding the debug instruction injector and the program loader.

Parameters:
- DATA_WIDTH, 32, instruction and immediate width (only 32 supported).
- CNT_WIDTH, 8, width of the saturating error counter (optional feature).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  request accepted when in_valid && in_ready.
- fmt  input  3  format code: 000 I, 001 S, 011 B, 100 U, 101 J; all other codes illegal.
- imm  input  DATA_WIDTH  signed immediate value (byte offset for B/J).
- base_inst  input  DATA_WIDTH  instruction word supplying opcode, rd, rs1, rs2 and funct bits.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer ready.
- out_inst  output  DATA_WIDTH  encoded instruction.
- out_err  output  1  range or format error for this result.
- err_cnt  output  CNT_WIDTH  saturating count of errored results (only with the optional feature).

Behaviour:
- Reset (async assert, sync release): s1_valid=0, out_valid=0, out_inst=0, out_err=0, err_cnt=0, in_ready=1.
- Stage 1 registers fmt, imm and base_inst on accept.
  - in_ready = !s1_valid || !out_valid || out_ready.
- Stage 2 computes the encoding combinationally from the stage-1 registers and loads the output register when s1_valid && (!out_valid || out_ready).
  - Latency: 2 cycles from accept to out_valid with no backpressure.
  - Throughput: 1 per cycle.
- out_valid, out_inst and out_err hold stable while out_valid && !out_ready.
- Range rules (err=1 if violated):
  - I and S: imm[31:11] all equal.
  - B: imm[0]==0 and imm[31:12] all equal.
  - U: imm[11:0]==0.
  - J: imm[0]==0 and imm[31:20] all equal.
  - Illegal fmt: always err.
- Placement:
  - I: inst[31:20]=imm[11:0].
  - S: inst[31:25]=imm[11:5], inst[11:7]=imm[4:0].
  - B: inst[31]=imm[12], inst[30:25]=imm[10:5], inst[11:8]=imm[4:1], inst[7]=imm[11].
  - U: inst[31:12]=imm[31:12].
  - J: inst[31]=imm[20], inst[30:21]=imm[10:1], inst[20]=imm[11], inst[19:12]=imm[19:12].
  - All remaining bits are copied from base_inst.
- On err: out_inst = base_inst with every immediate bit position of the selected format cleared; illegal fmt gives out_inst = base_inst unchanged.
- Simultaneous accept and drain is legal in the same cycle; no bubble is inserted.
- Reset mid-operation drops in-flight entries with no output.

Optional Feature:
- IMM_ENC_ERR_CNT_EN defined:
  - err_cnt increments by 1 each cycle the output register loads with err=1.
  - Saturates at all-ones and clears only on reset.
- Not defined: err_cnt is tied to 0 and the counter register is not instantiated.

Decomposition:
- Shared package imm_enc_pkg:
  - enum imm_fmt_t (FMT_I=3'b000, FMT_S=3'b001, FMT_B=3'b011, FMT_U=3'b100, FMT_J=3'b101).
  - Per-format immediate bit masks as 32-bit constants.
- One sub-module, imm_scatter: purely combinational fmt+imm+base_inst -> inst+err, instantiated between stage 1 and stage 2.

Test Plan:
- I-type: fmt=000, imm=-1, base_inst=0x00000013, out_ready=1 -> out_inst=0xFFF00013, err=0, out_valid exactly 2 cycles after accept.
- S-type overflow: fmt=001, imm=2048 -> err=1, out_inst=base_inst with bits [31:25] and [11:7] cleared.
- B-type: fmt=011, imm=-4096, base_inst=0x00000063 -> out_inst=0x80000063, err=0.
- B-type odd offset: fmt=011, imm=3 -> err=1.
- J-type: fmt=101, imm=0x000FFFFE, base_inst=0x0000006F -> out_inst=0x7FFFF06F.
- Backpressure: 4 back-to-back requests with out_ready=0 -> in_ready drops after 2 accepts, outputs hold stable.
  - Then release out_ready: all 4 results emerge in order with no loss or duplication.
  - Illegal fmt=010 mixed into the stream -> out_inst=base_inst, err=1.
  - With IMM_ENC_ERR_CNT_EN, err_cnt equals the number of errored results.
